// File: rtl/dcm_reset_sequencer_if.sv
// Signal bundle between the DCM reset sequencer (master) and the DCM/housekeeping side (slave).
// Clock and reset stay outside the bundle as plain ports of the sequencer.
interface dcm_reset_sequencer_if;
  logic       dcm_reset_req_i;
  logic [2:0] dcm_status_i;
  logic       dcm_reset_o;
  logic       dcm_ready_o;
  logic       fault_o;
  logic [2:0] retry_count_o;
  logic [7:0] lock_loss_count_o;
  logic [2:0] state_o;

  modport master (
    input  dcm_reset_req_i, dcm_status_i,
    output dcm_reset_o, dcm_ready_o, fault_o, retry_count_o, lock_loss_count_o, state_o
  );

  modport slave (
    output dcm_reset_req_i, dcm_status_i,
    input  dcm_reset_o, dcm_ready_o, fault_o, retry_count_o, lock_loss_count_o, state_o
  );
endinterface

// File: rtl/dcm_reset_sequencer.sv
// Sequences the CLK125->CLK250 DCM reset, waits for a stable lock and retries on timeout or lock loss.
// Runs on CLK33, which is independent of the DCM it controls.
module dcm_reset_sequencer #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  CLK33,
  input  logic                  rst_n_i,
  dcm_reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_RST_ASSERT = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_READY      = 3'd3,
    ST_FAULT      = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [2:0]           RETRY_MAX    = 3'(MAX_RETRIES);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           retry_q, retry_d;
  logic [7:0]           loss_q, loss_d;
  logic                 reset_q, reset_d;
  logic                 ready_q, ready_d;
  logic                 fault_q, fault_d;
  logic [1:0]           meta_q, sync_q;
  logic                 lock_ok_s;
  state_e               retry_state_s;
  logic [2:0]           retry_inc_s;
  logic                 unused_phase_ovf_s;

  // Bit 1 of the synchronized pair is LOCKED, bit 0 is CLKIN-stopped.
  assign lock_ok_s          = sync_q[1] & ~sync_q[0];
  assign unused_phase_ovf_s = bus.dcm_status_i[0];

  // Outcome of a retry: another reset attempt, or FAULT once the budget is spent.
  always_comb begin
    if (retry_q == RETRY_MAX) begin
      retry_state_s = ST_FAULT;
      retry_inc_s   = retry_q;
    end else begin
      retry_state_s = ST_RST_ASSERT;
      retry_inc_s   = retry_q + 3'd1;
    end
  end

  // Next-state, counter and statistics logic; a software request outranks everything except RST_ASSERT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      ST_RST_ASSERT: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (bus.dcm_reset_req_i) begin
          state_d = ST_RST_ASSERT;
          cnt_d   = CNT_ZERO;
          retry_d = 3'd0;
        end else if (lock_ok_s) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = retry_state_s;
          cnt_d   = CNT_ZERO;
          retry_d = retry_inc_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (bus.dcm_reset_req_i) begin
          state_d = ST_RST_ASSERT;
          cnt_d   = CNT_ZERO;
          retry_d = 3'd0;
        end else if (!lock_ok_s) begin
          state_d = retry_state_s;
          cnt_d   = CNT_ZERO;
          retry_d = retry_inc_s;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_READY;
          cnt_d   = CNT_ZERO;
          retry_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_READY: begin
        // A loss is counted even when a request arrives on the same cycle.
        if (!lock_ok_s && (loss_q != 8'hFF)) begin
          loss_d = loss_q + 8'd1;
        end else begin
          loss_d = loss_q;
        end
        if (bus.dcm_reset_req_i || !lock_ok_s) begin
          state_d = ST_RST_ASSERT;
          cnt_d   = CNT_ZERO;
          retry_d = 3'd0;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_FAULT: begin
        if (bus.dcm_reset_req_i) begin
          state_d = ST_RST_ASSERT;
          cnt_d   = CNT_ZERO;
          retry_d = 3'd0;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_RST_ASSERT;
        cnt_d   = CNT_ZERO;
        retry_d = 3'd0;
      end
    endcase
    reset_d = (state_d == ST_RST_ASSERT);
    ready_d = (state_d == ST_READY);
    fault_d = (state_d == ST_FAULT);
  end

  // State, counters, registered outputs and the two-flop status synchronizer.
  always_ff @(posedge CLK33) begin
    if (!rst_n_i) begin
      state_q <= ST_RST_ASSERT;
      cnt_q   <= CNT_ZERO;
      retry_q <= 3'd0;
      loss_q  <= 8'd0;
      reset_q <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      meta_q  <= 2'b00;
      sync_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
      reset_q <= reset_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      meta_q  <= bus.dcm_status_i[2:1];
      sync_q  <= meta_q;
    end
  end

  assign bus.dcm_reset_o       = reset_q;
  assign bus.dcm_ready_o       = ready_q;
  assign bus.fault_o           = fault_q;
  assign bus.retry_count_o     = retry_q;
  assign bus.lock_loss_count_o = loss_q;
  assign bus.state_o           = state_q;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Self-checking bench for dcm_reset_sequencer: randomized lock timing, glitches and requests
// compared against timing and counting rules derived directly from the sequencer's behaviour.
module tb_dcm_reset_sequencer;
  localparam int RST_CYC = 4;
  localparam int TIMEOUT = 100;
  localparam int SETTLE  = 16;
  localparam int MAXR    = 2;
  localparam int LIMIT   = 2000;
  // Ticks from entering RST_ASSERT (lock already synchronized) to dcm_ready_o rising.
  localparam int RELOCK  = RST_CYC + 1 + SETTLE;

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_READY  = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [2:0] LOCKED   = 3'b100;
  localparam logic [2:0] UNLOCKED = 3'b000;
  localparam logic [2:0] CLKSTOP  = 3'b110;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;
  int   model_losses = 0;

  dcm_reset_sequencer_if dut_if();

  dcm_reset_sequencer #(
    .RST_CYCLES(RST_CYC), .LOCK_TIMEOUT(TIMEOUT), .SETTLE_CYCLES(SETTLE),
    .MAX_RETRIES(MAXR), .CNT_WIDTH(16)
  ) dut (
    .CLK33  (clk),
    .rst_n_i(rst_n),
    .bus    (dut_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT just out of reset, in RST_ASSERT with its counter at zero.
  task automatic restart(input logic [2:0] status);
    rst_n = 1'b0;
    dut_if.dcm_reset_req_i = 1'b0;
    dut_if.dcm_status_i = status;
    tick();
    tick();
    rst_n = 1'b1;
    model_losses = 0;
  endtask

  task automatic wait_reset_level(input logic lvl, output int n);
    n = 0;
    while (dut_if.dcm_reset_o !== lvl && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (dut_if.dcm_ready_o !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_fault(output int n);
    n = 0;
    while (dut_if.fault_o !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dut_if.dcm_reset_req_i = 1'b1;
    dut_if.dcm_status_i = LOCKED;
    repeat (3) tick();
    n_total++; if (dut_if.state_o !== S_RST) $display("FAIL rst_state: got %0d want %0d", dut_if.state_o, S_RST); else n_pass++;
    n_total++; if (dut_if.dcm_reset_o !== 1'b1) $display("FAIL rst_dcm_reset: got %b want 1", dut_if.dcm_reset_o); else n_pass++;
    n_total++; if (dut_if.dcm_ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", dut_if.dcm_ready_o); else n_pass++;
    n_total++; if (dut_if.fault_o !== 1'b0) $display("FAIL rst_fault: got %b want 0", dut_if.fault_o); else n_pass++;
    n_total++; if (dut_if.retry_count_o !== 3'd0) $display("FAIL rst_retry: got %0d want 0", dut_if.retry_count_o); else n_pass++;
    n_total++; if (dut_if.lock_loss_count_o !== 8'd0) $display("FAIL rst_loss: got %0d want 0", dut_if.lock_loss_count_o); else n_pass++;
    dut_if.dcm_reset_req_i = 1'b0;
  endtask

  task automatic test_lock_sequence();
    for (int it = 0; it < 4; it++) begin
      int d, n;
      d = (it == 0) ? 10 : int'($urandom_range(0, 90));
      restart(UNLOCKED);
      wait_reset_level(1'b0, n);
      n_total++; if (n !== RST_CYC) $display("FAIL lock_pulse_width: got %0d want %0d", n, RST_CYC); else n_pass++;
      n_total++; if (dut_if.state_o !== S_WAIT) $display("FAIL lock_wait_state: got %0d want %0d", dut_if.state_o, S_WAIT); else n_pass++;
      repeat (d) tick();
      dut_if.dcm_status_i = LOCKED;
      tick();
      tick();
      n_total++; if (dut_if.state_o !== S_WAIT) $display("FAIL lock_sync_delay: got %0d want %0d", dut_if.state_o, S_WAIT); else n_pass++;
      tick();
      n_total++; if (dut_if.state_o !== S_SETTLE) $display("FAIL lock_settle_entry: got %0d want %0d", dut_if.state_o, S_SETTLE); else n_pass++;
      repeat (SETTLE - 1) tick();
      n_total++; if (dut_if.dcm_ready_o !== 1'b0) $display("FAIL lock_ready_early: got %b want 0", dut_if.dcm_ready_o); else n_pass++;
      tick();
      n_total++; if (dut_if.dcm_ready_o !== 1'b1) $display("FAIL lock_ready: got %b want 1", dut_if.dcm_ready_o); else n_pass++;
      n_total++; if (dut_if.state_o !== S_READY) $display("FAIL lock_ready_state: got %0d want %0d", dut_if.state_o, S_READY); else n_pass++;
      n_total++; if (dut_if.retry_count_o !== 3'd0) $display("FAIL lock_retry: got %0d want 0", dut_if.retry_count_o); else n_pass++;
    end
  endtask

  task automatic test_timeout_fault();
    int n;
    restart(UNLOCKED);
    for (int p = 0; p <= MAXR; p++) begin
      wait_reset_level(1'b0, n);
      n_total++; if (n !== RST_CYC) $display("FAIL to_pulse_width: got %0d want %0d", n, RST_CYC); else n_pass++;
      if (p < MAXR) begin
        wait_reset_level(1'b1, n);
        n_total++; if (n !== TIMEOUT) $display("FAIL to_wait_len: got %0d want %0d", n, TIMEOUT); else n_pass++;
        n_total++; if (dut_if.retry_count_o !== 3'(p + 1)) $display("FAIL to_retry: got %0d want %0d", dut_if.retry_count_o, p + 1); else n_pass++;
      end else begin
        wait_fault(n);
        n_total++; if (n !== TIMEOUT) $display("FAIL to_fault_time: got %0d want %0d", n, TIMEOUT); else n_pass++;
        n_total++; if (dut_if.state_o !== S_FAULT) $display("FAIL to_fault_state: got %0d want %0d", dut_if.state_o, S_FAULT); else n_pass++;
        n_total++; if (dut_if.retry_count_o !== 3'(MAXR)) $display("FAIL to_fault_retry: got %0d want %0d", dut_if.retry_count_o, MAXR); else n_pass++;
      end
    end
    repeat (20) tick();
    n_total++; if (dut_if.fault_o !== 1'b1) $display("FAIL to_fault_hold: got %b want 1", dut_if.fault_o); else n_pass++;
    n_total++; if (dut_if.dcm_reset_o !== 1'b0) $display("FAIL to_reset_low: got %b want 0", dut_if.dcm_reset_o); else n_pass++;
  endtask

  task automatic test_fault_request();
    int n;
    dut_if.dcm_reset_req_i = 1'b1;
    tick();
    dut_if.dcm_reset_req_i = 1'b0;
    n_total++; if (dut_if.state_o !== S_RST) $display("FAIL freq_state: got %0d want %0d", dut_if.state_o, S_RST); else n_pass++;
    n_total++; if (dut_if.fault_o !== 1'b0) $display("FAIL freq_fault: got %b want 0", dut_if.fault_o); else n_pass++;
    n_total++; if (dut_if.retry_count_o !== 3'd0) $display("FAIL freq_retry: got %0d want 0", dut_if.retry_count_o); else n_pass++;
    wait_reset_level(1'b0, n);
    n_total++; if (n !== RST_CYC) $display("FAIL freq_pulse_width: got %0d want %0d", n, RST_CYC); else n_pass++;
  endtask

  task automatic test_ready_loss();
    int n;
    restart(LOCKED);
    wait_ready(n);
    n_total++; if (n !== RELOCK) $display("FAIL loss_first_ready: got %0d want %0d", n, RELOCK); else n_pass++;
    dut_if.dcm_status_i = UNLOCKED;
    tick();
    dut_if.dcm_status_i = LOCKED;
    tick();
    n_total++; if (dut_if.dcm_ready_o !== 1'b1) $display("FAIL loss_ready_hold: got %b want 1", dut_if.dcm_ready_o); else n_pass++;
    tick();
    model_losses++;
    n_total++; if (dut_if.dcm_ready_o !== 1'b0) $display("FAIL loss_ready_drop: got %b want 0", dut_if.dcm_ready_o); else n_pass++;
    n_total++; if (dut_if.dcm_reset_o !== 1'b1) $display("FAIL loss_new_pulse: got %b want 1", dut_if.dcm_reset_o); else n_pass++;
    n_total++; if (dut_if.lock_loss_count_o !== 8'(model_losses)) $display("FAIL loss_count: got %0d want %0d", dut_if.lock_loss_count_o, model_losses); else n_pass++;
    wait_ready(n);
    for (int i = 1; i < 300; i++) begin
      int gap, len;
      logic [2:0] bad;
      gap = int'($urandom_range(0, 5));
      len = int'($urandom_range(1, 3));
      bad = ($urandom_range(0, 1) == 0) ? UNLOCKED : CLKSTOP;
      repeat (gap) tick();
      dut_if.dcm_status_i = bad;
      repeat (len) tick();
      dut_if.dcm_status_i = LOCKED;
      repeat (3 - len) tick();
      model_losses = (model_losses < 255) ? model_losses + 1 : 255;
      n_total++; if (dut_if.dcm_ready_o !== 1'b0) $display("FAIL loss_rep_drop: iter %0d got %b want 0", i, dut_if.dcm_ready_o); else n_pass++;
      n_total++; if (dut_if.lock_loss_count_o !== 8'(model_losses)) $display("FAIL loss_rep_count: iter %0d got %0d want %0d", i, dut_if.lock_loss_count_o, model_losses); else n_pass++;
      wait_ready(n);
      n_total++; if (n !== RELOCK) $display("FAIL loss_relock: iter %0d got %0d want %0d", i, n, RELOCK); else n_pass++;
    end
  endtask

  task automatic test_settle_drop();
    for (int it = 0; it < 3; it++) begin
      int p, n;
      p = (it == 0) ? 10 : int'($urandom_range(0, 13));
      restart(UNLOCKED);
      wait_reset_level(1'b0, n);
      dut_if.dcm_status_i = LOCKED;
      repeat (3) tick();
      n_total++; if (dut_if.state_o !== S_SETTLE) $display("FAIL sd_settle: got %0d want %0d", dut_if.state_o, S_SETTLE); else n_pass++;
      repeat (p) tick();
      dut_if.dcm_status_i = UNLOCKED;
      tick();
      dut_if.dcm_status_i = LOCKED;
      tick();
      n_total++; if (dut_if.dcm_ready_o !== 1'b0) $display("FAIL sd_no_ready: got %b want 0", dut_if.dcm_ready_o); else n_pass++;
      tick();
      n_total++; if (dut_if.state_o !== S_RST) $display("FAIL sd_state: p %0d got %0d want %0d", p, dut_if.state_o, S_RST); else n_pass++;
      n_total++; if (dut_if.retry_count_o !== 3'd1) $display("FAIL sd_retry: got %0d want 1", dut_if.retry_count_o); else n_pass++;
      n_total++; if (dut_if.dcm_ready_o !== 1'b0) $display("FAIL sd_ready: got %b want 0", dut_if.dcm_ready_o); else n_pass++;
    end
  endtask

  task automatic test_clkin_stopped();
    int n;
    restart(LOCKED);
    wait_ready(n);
    dut_if.dcm_status_i = CLKSTOP;
    tick();
    tick();
    n_total++; if (dut_if.dcm_ready_o !== 1'b1) $display("FAIL cs_ready_hold: got %b want 1", dut_if.dcm_ready_o); else n_pass++;
    tick();
    model_losses++;
    n_total++; if (dut_if.dcm_ready_o !== 1'b0) $display("FAIL cs_ready_drop: got %b want 0", dut_if.dcm_ready_o); else n_pass++;
    n_total++; if (dut_if.state_o !== S_RST) $display("FAIL cs_state: got %0d want %0d", dut_if.state_o, S_RST); else n_pass++;
    n_total++; if (dut_if.lock_loss_count_o !== 8'(model_losses)) $display("FAIL cs_loss: got %0d want %0d", dut_if.lock_loss_count_o, model_losses); else n_pass++;
    dut_if.dcm_status_i = LOCKED;
  endtask

  task automatic test_request_ready();
    int n;
    restart(LOCKED);
    wait_ready(n);
    dut_if.dcm_reset_req_i = 1'b1;
    tick();
    dut_if.dcm_reset_req_i = 1'b0;
    n_total++; if (dut_if.state_o !== S_RST) $display("FAIL rq_state: got %0d want %0d", dut_if.state_o, S_RST); else n_pass++;
    n_total++; if (dut_if.dcm_ready_o !== 1'b0) $display("FAIL rq_ready: got %b want 0", dut_if.dcm_ready_o); else n_pass++;
    n_total++; if (dut_if.lock_loss_count_o !== 8'd0) $display("FAIL rq_no_loss: got %0d want 0", dut_if.lock_loss_count_o); else n_pass++;
    wait_ready(n);
    dut_if.dcm_status_i = UNLOCKED;
    tick();
    tick();
    dut_if.dcm_reset_req_i = 1'b1;
    tick();
    dut_if.dcm_reset_req_i = 1'b0;
    dut_if.dcm_status_i = LOCKED;
    model_losses++;
    n_total++; if (dut_if.state_o !== S_RST) $display("FAIL rq_loss_state: got %0d want %0d", dut_if.state_o, S_RST); else n_pass++;
    n_total++; if (dut_if.lock_loss_count_o !== 8'(model_losses)) $display("FAIL rq_loss_count: got %0d want %0d", dut_if.lock_loss_count_o, model_losses); else n_pass++;
    n_total++; if (dut_if.retry_count_o !== 3'd0) $display("FAIL rq_retry: got %0d want 0", dut_if.retry_count_o); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int n, k;
    restart(LOCKED);
    wait_ready(n);
    dut_if.dcm_status_i = UNLOCKED;
    repeat (3) tick();
    n_total++; if (dut_if.lock_loss_count_o !== 8'd1) $display("FAIL mw_loss: got %0d want 1", dut_if.lock_loss_count_o); else n_pass++;
    wait_reset_level(1'b0, n);
    wait_reset_level(1'b1, n);
    n_total++; if (dut_if.retry_count_o !== 3'd1) $display("FAIL mw_retry: got %0d want 1", dut_if.retry_count_o); else n_pass++;
    wait_reset_level(1'b0, n);
    k = int'($urandom_range(5, 50));
    repeat (k) tick();
    n_total++; if (dut_if.state_o !== S_WAIT) $display("FAIL mw_wait_state: got %0d want %0d", dut_if.state_o, S_WAIT); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_total++; if (dut_if.state_o !== S_RST) $display("FAIL mw_rst_state: got %0d want %0d", dut_if.state_o, S_RST); else n_pass++;
    n_total++; if (dut_if.dcm_reset_o !== 1'b1) $display("FAIL mw_rst_reset: got %b want 1", dut_if.dcm_reset_o); else n_pass++;
    n_total++; if (dut_if.retry_count_o !== 3'd0) $display("FAIL mw_rst_retry: got %0d want 0", dut_if.retry_count_o); else n_pass++;
    n_total++; if (dut_if.lock_loss_count_o !== 8'd0) $display("FAIL mw_rst_loss: got %0d want 0", dut_if.lock_loss_count_o); else n_pass++;
    n_total++; if (dut_if.fault_o !== 1'b0 || dut_if.dcm_ready_o !== 1'b0) $display("FAIL mw_rst_flags: got fault %b ready %b want 0 0", dut_if.fault_o, dut_if.dcm_ready_o); else n_pass++;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    dut_if.dcm_reset_req_i = 1'b0;
    dut_if.dcm_status_i = UNLOCKED;
    test_reset();
    test_lock_sequence();
    test_timeout_fault();
    test_fault_request();
    test_ready_loss();
    test_settle_drop();
    test_clkin_stopped();
    test_request_ready();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
